// File: rtl/jkff_pkg.sv
// Shared encodings for the JK flip-flop bank arbiter: FSM states, JK opcodes
// and the per-bit JK next-state function.
package jkff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  function automatic logic jk_next(input logic jb, input logic kb, input logic qb);
    logic r;
    case ({jb, kb})
      JK_HOLD: r = qb;
      JK_RST:  r = 1'b0;
      JK_SET:  r = 1'b1;
      default: r = ~qb;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jkff_bank_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping modulo N. Returns both a one-hot grant and its binary index.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic          found;
  logic [IW-1:0] cand;
  int            c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    c     = 0;
    for (int off = 0; off < N; off++) begin
      c = int'(ptr_i) + off;
      if (c >= N) c = c - N;
      cand = IW'(c);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/jkff_bank_arbiter.sv
// Bank of WIDTH JK flip-flops shared by NREQ requesters; a round-robin
// arbiter grants one requester per IDLE -> APPLY -> ACK operation.
module jkff_bank_arbiter
  import jkff_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] j,
  input  logic [NREQ*WIDTH-1:0] k,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qbar
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     sel_q, sel_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  jreg_q, jreg_d;
  logic [WIDTH-1:0]  kreg_q, kreg_d;
  logic [WIDTH-1:0]  bank_q, bank_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [IW-1:0]     arb_idx;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    jreg_d  = jreg_q;
    kreg_d  = kreg_q;
    bank_d  = bank_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          sel_d   = arb_idx;
          gnt_d   = arb_gnt;
          jreg_d  = j[arb_idx*WIDTH +: WIDTH];
          kreg_d  = k[arb_idx*WIDTH +: WIDTH];
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        for (int b = 0; b < WIDTH; b++) begin
          bank_d[b] = jk_next(jreg_q[b], kreg_q[b], bank_q[b]);
        end
        state_d = ST_ACK;
      end
      ST_ACK: begin
        // The just-served requester becomes lowest priority next round.
        ptr_d   = (sel_q == IW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      jreg_q  <= '0;
      kreg_q  <= '0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      jreg_q  <= jreg_d;
      kreg_q  <= kreg_d;
      bank_q  <= bank_d;
    end
  end

  // done is decoded from state so it can never glitch off req.
  assign gnt  = gnt_q;
  assign done = (state_q == ST_ACK) ? gnt_q : '0;
  assign busy = (state_q != ST_IDLE);
  assign q    = bank_q;
  assign qbar = ~bank_q;

endmodule
